elevator_scan_ctrl: RTL and testbench
=====================================

# elevator_scan_ctrl

Parametrised multi-request elevator car controller that latches hall/car calls into a pending-floor bitmap and serves them in SCAN order, continuing in the current direction while calls remain ahead. It sequences the door through a dwell/close handshake and raises door-held and overweight alerts. It sits between the call-button decode logic and the motor/door drive logic, one instance per car.

## Interface
- NUM_FLOORS, 16, number of served floors (2..2^FLOOR_W)
- FLOOR_W, 4, floor index width
- DWELL_CYC, 5, cycles the door is held open after arrival
- ALERT_CYC, 180, cycles door may be not-closed before door_alert
- TMR_W, 8, width of the dwell and alert counters (must hold ALERT_CYC)

- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- init_floor  in  FLOOR_W  floor loaded into cur_floor during reset
- req_valid  in  1  call strobe, one request per cycle
- req_floor  in  FLOOR_W  requested floor; values >= NUM_FLOORS are ignored
- floor_sensor  in  1  one-cycle pulse per floor crossed while moving
- door_closed  in  1  door fully closed
- over_weight  in  1  car load above limit
- cur_floor  out  FLOOR_W  last floor reached
- direction  out  1  1 = up, 0 = down
- moving  out  1  motor run command
- door_open_cmd  out  1  door drive: 1 = open/hold, 0 = close
- arrived  out  1  one-cycle pulse on servicing a floor
- pending  out  NUM_FLOORS  outstanding calls, bit i = floor i
- door_alert  out  1  door not closed for >= ALERT_CYC cycles
- weight_alert  out  1  registered copy of over_weight

## Operation
- Reset: cur_floor=init_floor, direction=1, moving=0, door_open_cmd=0, arrived=0, pending=0, door_alert=0, weight_alert=0, state IDLE, counters 0.
- Request: req_valid with valid floor sets pending[req_floor], except in DOOR when req_floor==cur_floor (dwell counter restarts, bit stays 0).
- States IDLE, MOVE, DOOR, CLOSE.
- IDLE: if over_weight or pending[cur_floor] -> DOOR (clear bit, pulse arrived if bit was set). Else if pending nonzero: keep direction if any pending bit lies on that side of cur_floor, otherwise invert; -> MOVE, moving=1.
- MOVE: on floor_sensor, cur_floor +/-1 per direction; pulse ignored if it would step below 0 or above NUM_FLOORS-1. If pending[new floor] set -> DOOR, clear bit, arrived pulse, moving=0. over_weight in MOVE only updates weight_alert.
- DOOR: door_open_cmd=1; dwell counter increments; over_weight holds it at 0. On reaching DWELL_CYC with over_weight=0 -> CLOSE.
- CLOSE: door_open_cmd=0; door_closed=1 -> IDLE; over_weight or same-floor request -> DOOR with dwell reset.
- Alert counter: increments (saturating at 2^TMR_W-1) while door_closed=0, clears when 1; door_alert=1 while count >= ALERT_CYC.
- Simultaneous arrival at F and request for F: serviced, bit ends 0.

## Timing
- All outputs registered; pending bit visible 1 cycle after req_valid.
- Floor-sensor pulse to cur_floor update: 1 cycle; arrived and moving=0 in the same cycle as the update.
- IDLE decision to moving=1: 1 cycle. Door open duration: DWELL_CYC cycles from DOOR entry, minimum.
- weight_alert follows over_weight with 1-cycle latency.
- Reset mid-move: immediate return to reset values; pending calls are lost.

## Configuration
- ELEV_FIRE_RECALL_EN defined: adds input fire_recall (1 bit). While high: pending forced to 0, requests ignored, direction forced down, car moves to floor 0, then DOOR with door held open (dwell does not expire) until fire_recall falls; then normal CLOSE.
- Undefined: no fire_recall port, no recall logic.

## Test plan
- Reset with init_floor=3 -> cur_floor=3, direction=1, all other outputs 0.
- At floor 2, requests 5 then 1; 3 sensor pulses -> arrived at 5, door opens 5 cycles, close, then direction=0, 4 pulses -> arrived at 1.
- req_floor=20 with NUM_FLOORS=16 -> pending unchanged, car stays IDLE.
- over_weight high in DOOR for 50 cycles -> door_open_cmd stays 1, weight_alert=1; CLOSE entered DWELL_CYC cycles after release.
- door_closed held 0 in CLOSE for 180 cycles -> door_alert=1; door_closed=1 -> door_alert 0 next cycle, state IDLE.
- ELEV_FIRE_RECALL_EN: at floor 6 moving up with calls 9, 12; assert fire_recall -> pending=0, 6 down pulses to floor 0, door held open until release.

Source files
------------

// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: single-car SCAN controller.
// Latches hall/car calls into a pending bitmap, keeps travelling in the current
// direction while calls remain ahead, sequences the door through dwell/close,
// and raises door-held and overweight alerts.
// Optional feature: define ELEV_FIRE_RECALL_EN to add the fire_recall input
// (send car to floor 0 and hold the door open while recall is active).
module elevator_scan_ctrl #(
  parameter int NUM_FLOORS = 16,
  parameter int FLOOR_W    = 4,
  parameter int DWELL_CYC  = 5,
  parameter int ALERT_CYC  = 180,
  parameter int TMR_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FLOOR_W-1:0]    init_floor,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic                  floor_sensor,
  input  logic                  door_closed,
  input  logic                  over_weight,
`ifdef ELEV_FIRE_RECALL_EN
  input  logic                  fire_recall,
`endif
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic                  direction,
  output logic                  moving,
  output logic                  door_open_cmd,
  output logic                  arrived,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_alert,
  output logic                  weight_alert
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MOVE  = 2'd1;
  localparam logic [1:0] S_DOOR  = 2'd2;
  localparam logic [1:0] S_CLOSE = 2'd3;

  localparam logic [FLOOR_W:0]   NF_W      = (FLOOR_W+1)'(NUM_FLOORS);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS-1);
  localparam logic [TMR_W-1:0]   DWELL_END = TMR_W'(DWELL_CYC-1);
  localparam logic [TMR_W-1:0]   ALERT_LIM = TMR_W'(ALERT_CYC);

  logic [1:0]            state_q, state_d;
  logic [FLOOR_W-1:0]    cur_floor_q, cur_floor_d;
  logic                  dir_q, dir_d;
  logic                  moving_q, moving_d;
  logic                  door_q, door_d;
  logic                  arrived_q, arrived_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [TMR_W-1:0]      dwell_q, dwell_d;
  logic [TMR_W-1:0]      alert_q, alert_d;
  logic                  door_alert_q, door_alert_d;
  logic                  weight_q;

  logic                  recall;
  logic                  req_ok, same_floor, cur_hit, above, below;
  logic [FLOOR_W-1:0]    nf;
  logic                  step_ok;

`ifdef ELEV_FIRE_RECALL_EN
  assign recall = fire_recall;
`else
  assign recall = 1'b0;
`endif

  function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] o;
    for (int i = 0; i < NUM_FLOORS; i++) o[i] = (f == FLOOR_W'(i));
    return o;
  endfunction

  function automatic logic bit_at(input logic [NUM_FLOORS-1:0] v,
                                  input logic [FLOOR_W-1:0] f);
    return |(v & onehot(f));
  endfunction

  // Call latching, SCAN direction choice and car/door state sequencing
  always_comb begin
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    dir_d       = dir_q;
    moving_d    = moving_q;
    door_d      = door_q;
    arrived_d   = 1'b0;
    dwell_d     = dwell_q;
    above       = 1'b0;
    below       = 1'b0;
    nf          = cur_floor_q;
    step_ok     = 1'b0;

    req_ok     = req_valid && ({1'b0, req_floor} < NF_W) && !recall;
    same_floor = req_ok && (req_floor == cur_floor_q);
    pending_d  = pending_q | (req_ok ? onehot(req_floor) : '0);
    cur_hit    = bit_at(pending_q, cur_floor_q);

    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (FLOOR_W'(i) > cur_floor_q) above = above | pending_q[i];
      if (FLOOR_W'(i) < cur_floor_q) below = below | pending_q[i];
    end

    if (dir_q) begin
      step_ok = (cur_floor_q != TOP_FLOOR);
      nf      = cur_floor_q + 1'b1;
    end else begin
      step_ok = (cur_floor_q != '0);
      nf      = cur_floor_q - 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (over_weight || cur_hit) begin
          state_d   = S_DOOR;
          door_d    = 1'b1;
          dwell_d   = '0;
          arrived_d = cur_hit;
          pending_d = pending_d & ~onehot(cur_floor_q);
        end else if (|pending_q) begin
          // Keep heading while calls remain ahead, otherwise reverse.
          dir_d    = dir_q ? above : !below;
          moving_d = 1'b1;
          state_d  = S_MOVE;
        end
      end
      S_MOVE: begin
        if (floor_sensor && step_ok) begin
          cur_floor_d = nf;
          if (bit_at(pending_d, nf)) begin
            pending_d = pending_d & ~onehot(nf);
            arrived_d = 1'b1;
            moving_d  = 1'b0;
            door_d    = 1'b1;
            dwell_d   = '0;
            state_d   = S_DOOR;
          end
        end
      end
      S_DOOR: begin
        door_d = 1'b1;
        if (same_floor || over_weight) begin
          pending_d = pending_d & ~onehot(cur_floor_q);
          dwell_d   = '0;
        end else if (dwell_q >= DWELL_END) begin
          door_d  = 1'b0;
          dwell_d = '0;
          state_d = S_CLOSE;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      default: begin
        door_d = 1'b0;
        if (over_weight || same_floor) begin
          pending_d = pending_d & ~onehot(cur_floor_q);
          door_d    = 1'b1;
          dwell_d   = '0;
          state_d   = S_DOOR;
        end else if (door_closed) begin
          state_d = S_IDLE;
        end
      end
    endcase

    // Fire recall: drop all calls, head down to floor 0 and hold the door there.
    if (recall) begin
      pending_d = '0;
      dir_d     = 1'b0;
      arrived_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cur_floor_q == '0) begin
            state_d = S_DOOR;
            door_d  = 1'b1;
            dwell_d = '0;
          end else begin
            state_d  = S_MOVE;
            moving_d = 1'b1;
          end
        end
        S_MOVE: begin
          cur_floor_d = cur_floor_q;
          moving_d    = 1'b1;
          state_d     = S_MOVE;
          if (cur_floor_q == '0 || (floor_sensor && cur_floor_q == FLOOR_W'(1))) begin
            cur_floor_d = '0;
            moving_d    = 1'b0;
            door_d      = 1'b1;
            dwell_d     = '0;
            state_d     = S_DOOR;
          end else if (floor_sensor) begin
            cur_floor_d = cur_floor_q - 1'b1;
          end
        end
        S_DOOR: begin
          if (cur_floor_q == '0) begin
            state_d = S_DOOR;
            door_d  = 1'b1;
            dwell_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Door-not-closed timer, saturating, and its threshold flag
  always_comb begin
    alert_d = alert_q;
    if (door_closed) alert_d = '0;
    else if (alert_q != '1) alert_d = alert_q + 1'b1;
    door_alert_d = (alert_d >= ALERT_LIM);
  end

  // State and output registers, asynchronously reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cur_floor_q  <= init_floor;
      dir_q        <= 1'b1;
      moving_q     <= 1'b0;
      door_q       <= 1'b0;
      arrived_q    <= 1'b0;
      pending_q    <= '0;
      dwell_q      <= '0;
      alert_q      <= '0;
      door_alert_q <= 1'b0;
      weight_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_floor_q  <= cur_floor_d;
      dir_q        <= dir_d;
      moving_q     <= moving_d;
      door_q       <= door_d;
      arrived_q    <= arrived_d;
      pending_q    <= pending_d;
      dwell_q      <= dwell_d;
      alert_q      <= alert_d;
      door_alert_q <= door_alert_d;
      weight_q     <= over_weight;
    end
  end

  assign cur_floor     = cur_floor_q;
  assign direction     = dir_q;
  assign moving        = moving_q;
  assign door_open_cmd = door_q;
  assign arrived       = arrived_q;
  assign pending       = pending_q;
  assign door_alert    = door_alert_q;
  assign weight_alert  = weight_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl with an arrival scoreboard.
// Expected arrival floors are queued when calls are issued and popped when
// the controller pulses arrived. Define ELEV_FIRE_RECALL_EN to add the recall scenario.
module tb_elevator_scan_ctrl;
  localparam int NF = 16;
  localparam int FW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [FW-1:0] init_floor;
  logic          req_valid;
  logic [FW-1:0] req_floor;
  logic          floor_sensor;
  logic          door_closed;
  logic          over_weight;
`ifdef ELEV_FIRE_RECALL_EN
  logic          fire_recall;
`endif
  logic [FW-1:0] cur_floor;
  logic          direction, moving, door_open_cmd, arrived, door_alert, weight_alert;
  logic [NF-1:0] pending;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];

  elevator_scan_ctrl #(.NUM_FLOORS(NF), .FLOOR_W(FW), .DWELL_CYC(5),
                       .ALERT_CYC(180), .TMR_W(8)) dut (
    .clk(clk), .reset(reset), .init_floor(init_floor), .req_valid(req_valid),
    .req_floor(req_floor), .floor_sensor(floor_sensor), .door_closed(door_closed),
    .over_weight(over_weight),
`ifdef ELEV_FIRE_RECALL_EN
    .fire_recall(fire_recall),
`endif
    .cur_floor(cur_floor), .direction(direction), .moving(moving),
    .door_open_cmd(door_open_cmd), .arrived(arrived), .pending(pending),
    .door_alert(door_alert), .weight_alert(weight_alert));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input int f, input bit expect_arrival);
    req_valid = 1'b1;
    req_floor = FW'(f);
    if (expect_arrival) exp_q.push_back(f);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic pulse();
    floor_sensor = 1'b1;
    tick();
    floor_sensor = 1'b0;
  endtask

  // Count cycles door_open_cmd stays high from now, bounded
  task automatic door_cycles(output int n);
    n = 0;
    while (door_open_cmd === 1'b1 && n < 400) begin
      n++;
      tick();
    end
  endtask

  // Scoreboard: every arrival pulse must match the next queued floor
  always @(negedge clk) begin
    if (reset === 1'b0 && arrived === 1'b1) begin
      if (exp_q.size() == 0) chk("arrive_unexpected", 32'(cur_floor), 32'hFFFF);
      else chk("arrive_floor", 32'(cur_floor), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1; init_floor = FW'(3); req_valid = 1'b0; req_floor = '0;
    floor_sensor = 1'b0; door_closed = 1'b1; over_weight = 1'b0;
`ifdef ELEV_FIRE_RECALL_EN
    fire_recall = 1'b0;
`endif
    tick(); tick();
    chk("rst_floor", 32'(cur_floor), 32'd3);
    chk("rst_dir", 32'(direction), 32'd1);
    chk("rst_outs", {26'd0, moving, door_open_cmd, arrived, door_alert, weight_alert, |pending}, 32'd0);

    init_floor = FW'(2);
    tick();
    reset = 1'b0;
    tick();
    chk("start_floor", 32'(cur_floor), 32'd2);

    // Requests 5 then 1 from floor 2
    request(5, 1'b1);
    chk("pend_5", 32'(pending), 32'h0020);
    request(1, 1'b1);
    chk("pend_5_1", 32'(pending), 32'h0022);
    chk("move_start", 32'(moving), 32'd1);
    chk("dir_up", 32'(direction), 32'd1);
    pulse(); tick();
    chk("floor3", 32'(cur_floor), 32'd3);
    pulse(); tick();
    pulse();
    chk("arr5_floor", 32'(cur_floor), 32'd5);
    chk("arr5_stop", 32'(moving), 32'd0);
    chk("arr5_pend", 32'(pending), 32'h0002);
    door_cycles(n);
    chk("dwell_5", 32'(n), 32'd5);
    tick(); tick();
    chk("rev_dir", 32'(direction), 32'd0);
    chk("rev_move", 32'(moving), 32'd1);
    repeat (4) begin pulse(); tick(); end
    chk("arr1_floor", 32'(cur_floor), 32'd1);
    chk("arr1_pend", 32'(pending), 32'h0000);
    door_cycles(n);
    tick();

    // Out-of-range request ignored
    request(20, 1'b0);
    chk("bad_req_pend", 32'(pending), 32'h0000);
    tick();
    chk("bad_req_idle", 32'(moving), 32'd0);

    // Same-floor call in IDLE, then overweight holds the door
    request(1, 1'b1);
    chk("pend_cur", 32'(pending), 32'h0002);
    tick();
    chk("door_open", 32'(door_open_cmd), 32'd1);
    over_weight = 1'b1;
    repeat (50) tick();
    chk("ow_door", 32'(door_open_cmd), 32'd1);
    chk("ow_alert", 32'(weight_alert), 32'd1);
    over_weight = 1'b0;
    door_cycles(n);
    chk("ow_release_dwell", 32'(n), 32'd5);
    chk("ow_alert_clr", 32'(weight_alert), 32'd0);

    // Door held open (not closed) in CLOSE
    door_closed = 1'b0;
    repeat (179) tick();
    chk("alert_179", 32'(door_alert), 32'd0);
    tick();
    chk("alert_180", 32'(door_alert), 32'd1);
    chk("alert_closing", 32'(door_open_cmd), 32'd0);
    door_closed = 1'b1;
    tick();
    chk("alert_clr", 32'(door_alert), 32'd0);

    // IDLE again: call to 3 reverses to up; same-floor call in DOOR extends dwell
    request(3, 1'b1);
    tick();
    chk("dir_up2", 32'(direction), 32'd1);
    chk("move3", 32'(moving), 32'd1);
    pulse(); tick();
    pulse();
    chk("arr3_floor", 32'(cur_floor), 32'd3);
    tick(); tick();
    request(3, 1'b0);
    chk("door_req_pend", 32'(pending), 32'h0000);
    door_cycles(n);
    chk("door_req_dwell", 32'(n), 32'd5);
    tick();

    // Reset mid-move drops calls immediately
    request(8, 1'b0);
    tick();
    pulse();
    chk("pre_rst_floor", 32'(cur_floor), 32'd4);
    init_floor = FW'(7);
    reset = 1'b1;
    #1;
    chk("midrst_move", 32'(moving), 32'd0);
    chk("midrst_pend", 32'(pending), 32'h0000);
    chk("midrst_floor", 32'(cur_floor), 32'd7);

`ifdef ELEV_FIRE_RECALL_EN
    init_floor = FW'(6);
    tick();
    reset = 1'b0;
    tick();
    request(9, 1'b0);
    request(12, 1'b0);
    chk("fr_move", 32'(moving), 32'd1);
    fire_recall = 1'b1;
    tick();
    chk("fr_pend", 32'(pending), 32'h0000);
    chk("fr_dir", 32'(direction), 32'd0);
    repeat (6) begin pulse(); tick(); end
    chk("fr_floor", 32'(cur_floor), 32'd0);
    chk("fr_stop", 32'(moving), 32'd0);
    repeat (20) tick();
    chk("fr_hold", 32'(door_open_cmd), 32'd1);
    fire_recall = 1'b0;
    door_cycles(n);
    chk("fr_release", 32'(n), 32'd5);
`endif

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
